// File: rtl/aes_cipher_seq_if.sv
// Block handshake bundle between a requester and the AES-128 cipher sequencer.
// master = requester side, slave = cipher side.
interface aes_cipher_seq_if;
    logic           in_valid;
    logic           in_ready;
    logic [0:127]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [0:127]   out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_cipher_seq.sv
// AES-128 encryption sequencer: initial AddRoundKey plus 10 rounds, one round per clock.
// Optional macro AES_KEY_LATCH_EN captures the expanded key on accept instead of reading it live.
module aes_cipher_seq #(
    parameter int NR      = 10,
    parameter int WORDS_W = 128 * (NR + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [0:WORDS_W-1]   words,
    aes_cipher_seq_if.slave      io,
    output logic                 busy,
    output logic [3:0]           round_idx
);

    typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} fsm_e;

    localparam logic [3:0] LAST_MID = 4'(NR - 1);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, so 0 maps to 0) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (i != 0) r = gmul(r, a);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    // Byte r+4c is row r, column c; row r rotates left by r columns.
    function automatic logic [0:127] sub_shift(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[8*(r+4*c) +: 8] = sbox(s[8*(r+4*((c+r)&3)) +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    fsm_e           fsm_q, fsm_d;
    logic [0:127]   st_q, st_d;
    logic [3:0]     round_q, round_d;
    logic [0:127]   out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic [0:WORDS_W-1] kbus;
    logic [0:127]   rk;
    logic [0:127]   sr;
    logic [0:127]   mc;

`ifdef AES_KEY_LATCH_EN
    logic [0:WORDS_W-1] key_q;

    always_ff @(posedge clk) begin
        if (fsm_q == IDLE && io.in_valid) key_q <= words;
    end

    assign kbus = key_q;
`else
    assign kbus = words;
`endif

    // round_q doubles as the key index: 0 in INIT, 1..9 in ROUND, 10 in FINAL.
    assign rk = kbus[{round_q, 7'b0} +: 128];
    assign sr = sub_shift(st_q);
    assign mc = mix_columns(sr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            st_q        <= '0;
            round_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            st_q        <= st_d;
            round_q     <= round_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        st_d        = st_q;
        round_d     = round_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (fsm_q)
            IDLE: begin
                if (io.in_valid) begin
                    st_d  = io.in_data;
                    fsm_d = INIT;
                end
            end
            INIT: begin
                st_d    = st_q ^ rk;
                round_d = 4'd1;
                fsm_d   = ROUND;
            end
            ROUND: begin
                st_d    = mc ^ rk;
                round_d = round_q + 4'd1;
                if (round_q == LAST_MID) fsm_d = FINAL;
            end
            FINAL: begin
                out_data_d = sr ^ rk;
                round_d    = 4'd0;
                fsm_d      = DONE;
            end
            DONE: begin
                // First DONE cycle is the output register stage; valid rises after it.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign io.in_ready  = (fsm_q == IDLE);
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign busy         = (fsm_q == INIT) || (fsm_q == ROUND) || (fsm_q == FINAL);
    assign round_idx    = round_q;

endmodule

// File: tb/tb_aes_cipher_seq.sv
// Bench for aes_cipher_seq: FIPS-197 vectors plus random blocks against a matrix-level AES model.
// Define AES_KEY_LATCH_EN for both bench and RTL to exercise the key-capture option.
module tb_aes_cipher_seq;

    logic           clk = 1'b0;
    logic           rst;
    logic [0:1407]  words;
    logic           busy;
    logic [3:0]     round_idx;

    aes_cipher_seq_if bus ();

    aes_cipher_seq dut (
        .clk       (clk),
        .rst       (rst),
        .words     (words),
        .io        (bus),
        .busy      (busy),
        .round_idx (round_idx)
    );

    always #5 clk = ~clk;

    localparam logic [0:127] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] sb [256];

    // ---------------- reference model ----------------
    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Walk the multiplicative group with generator 3 (p) and its inverse (q) to fill the S-box.
    task automatic build_sbox;
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [0:1407] expand(input logic [0:127] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1407] r;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    function automatic logic [0:127] aes_ref(input logic [0:127] pt, input logic [0:1407] ks);
        logic [7:0]   m [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   a0, a1, a2, a3;
        logic [0:127] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                m[r][c] = pt[8*(r+4*c) +: 8] ^ ks[8*(r+4*c) +: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sb[m[r][(c+r)%4]];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
                    t[0][c] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    t[1][c] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    t[2][c] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    t[3][c] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    m[r][c] = t[r][c] ^ ks[128*rnd + 8*(r+4*c) +: 8];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*(r+4*c) +: 8] = m[r][c];
        return o;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic [0:127] pt, input logic [0:127] key);
        int n;
        words        = expand(key);
        bus.in_data  = pt;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick;
            n++;
        end
        tick;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cnt);
        cnt = 0;
        while (!bus.out_valid && cnt < 60) begin
            tick;
            cnt++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        words         = '0;
        tick;
        tick;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_data !== 128'h0) $display("FAIL reset_out_data: got %h want 0", bus.out_data); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (round_idx !== 4'd0) $display("FAIL reset_round_idx: got %0d want 0", round_idx); else n_pass++;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_fips_c1_trace;
        logic [3:0] exp_round;
        logic       exp_busy, exp_ov;
        bus.out_ready = 1'b1;
        words         = expand(C1_KEY);
        bus.in_data   = C1_PT;
        bus.in_valid  = 1'b1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL c1_idle_ready: got %b want 1", bus.in_ready); else n_pass++;
        tick;
        bus.in_valid = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            exp_round = (k >= 1 && k <= 10) ? 4'(k) : 4'd0;
            exp_busy  = (k <= 10);
            exp_ov    = (k >= 12);
            n_total++;
            if ({busy, round_idx, bus.out_valid} !== {exp_busy, exp_round, exp_ov})
                $display("FAIL trace_k%0d: busy/round/valid got %b/%0d/%b want %b/%0d/%b",
                         k, busy, round_idx, bus.out_valid, exp_busy, exp_round, exp_ov);
            else n_pass++;
            if (k < 12) tick;
        end
        n_total++; if (bus.out_data !== C1_CT) $display("FAIL c1_vector: got %h want %h", bus.out_data, C1_CT); else n_pass++;
        n_total++; if (bus.out_data !== aes_ref(C1_PT, expand(C1_KEY))) $display("FAIL c1_model: got %h want %h", bus.out_data, aes_ref(C1_PT, expand(C1_KEY))); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL c1_done_ready: got %b want 0", bus.in_ready); else n_pass++;
        tick;
        n_total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) $display("FAIL c1_release: valid/ready got %b want 01", {bus.out_valid, bus.in_ready}); else n_pass++;
    endtask

    task automatic test_backpressure;
        int           cnt;
        logic [0:127] pt, held;
        pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.out_ready = 1'b0;
        start_block(pt, C1_KEY);
        wait_out(cnt);
        n_total++; if (cnt !== 12) $display("FAIL bp_latency: got %0d want 12", cnt); else n_pass++;
        held = bus.out_data;
        n_total++; if (held !== aes_ref(pt, expand(C1_KEY))) $display("FAIL bp_data: got %h want %h", held, aes_ref(pt, expand(C1_KEY))); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            tick;
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.in_ready !== 1'b0)
                $display("FAIL bp_hold_%0d: valid/ready got %b/%b data %h want 1/0 data %h",
                         i, bus.out_valid, bus.in_ready, bus.out_data, held);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        tick;
        n_total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) $display("FAIL bp_release: valid/ready got %b want 01", {bus.out_valid, bus.in_ready}); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int cnt;
        bus.out_ready = 1'b1;
        words         = expand(C1_KEY);
        bus.in_data   = C1_PT;
        bus.in_valid  = 1'b1;
        tick;
        bus.in_data = '0;
        wait_out(cnt);
        n_total++; if (cnt !== 12) $display("FAIL b2b_lat_a: got %0d want 12", cnt); else n_pass++;
        n_total++; if (bus.out_data !== C1_CT) $display("FAIL b2b_data_a: got %h want %h", bus.out_data, C1_CT); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_ignored: in_ready got %b want 0", bus.in_ready); else n_pass++;
        tick;
        words = expand(128'h0);
        n_total++; if ({bus.out_valid, bus.in_ready} !== 2'b01) $display("FAIL b2b_gap: valid/ready got %b want 01", {bus.out_valid, bus.in_ready}); else n_pass++;
        tick;
        bus.in_valid = 1'b0;
        n_total++; if ({busy, bus.in_ready} !== 2'b10) $display("FAIL b2b_accept_b: busy/ready got %b want 10", {busy, bus.in_ready}); else n_pass++;
        wait_out(cnt);
        n_total++; if (cnt !== 12) $display("FAIL b2b_lat_b: got %0d want 12", cnt); else n_pass++;
        n_total++; if (bus.out_data !== Z_CT) $display("FAIL b2b_data_b: got %h want %h", bus.out_data, Z_CT); else n_pass++;
        n_total++; if (bus.out_data !== aes_ref(128'h0, expand(128'h0))) $display("FAIL b2b_model_b: got %h want %h", bus.out_data, aes_ref(128'h0, expand(128'h0))); else n_pass++;
        tick;
    endtask

    task automatic test_reset_mid;
        int   cnt;
        logic seen;
        bus.out_ready = 1'b1;
        start_block(C1_PT, C1_KEY);
        cnt = 0;
        while (round_idx !== 4'd5 && cnt < 20) begin
            tick;
            cnt++;
        end
        n_total++; if (round_idx !== 4'd5) $display("FAIL rmid_reach5: got %0d want 5", round_idx); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({bus.in_ready, bus.out_valid, busy, round_idx} !== {1'b1, 1'b0, 1'b0, 4'd0} || bus.out_data !== 128'h0)
            $display("FAIL rmid_outputs: ready/valid/busy/round got %b/%b/%b/%0d data %h want 1/0/0/0 data 0",
                     bus.in_ready, bus.out_valid, busy, round_idx, bus.out_data);
        else n_pass++;
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick;
            if (bus.out_valid) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL rmid_no_partial: out_valid seen %b want 0", seen); else n_pass++;
        start_block(C1_PT, C1_KEY);
        wait_out(cnt);
        n_total++; if (cnt !== 12) $display("FAIL rmid_rerun_lat: got %0d want 12", cnt); else n_pass++;
        n_total++; if (bus.out_data !== C1_CT) $display("FAIL rmid_rerun_data: got %h want %h", bus.out_data, C1_CT); else n_pass++;
        tick;
    endtask

    task automatic test_random;
        int           cnt, hold;
        logic [0:127] pt, key, exp_ct;
        for (int n = 0; n < 6; n++) begin
            pt   = {$urandom(), $urandom(), $urandom(), $urandom()};
            key  = {$urandom(), $urandom(), $urandom(), $urandom()};
            hold = $urandom_range(0, 3);
            exp_ct = aes_ref(pt, expand(key));
            bus.out_ready = 1'b0;
            start_block(pt, key);
            wait_out(cnt);
            n_total++; if (cnt !== 12) $display("FAIL rand%0d_latency: got %0d want 12", n, cnt); else n_pass++;
            n_total++; if (bus.out_data !== exp_ct) $display("FAIL rand%0d_data: got %h want %h", n, bus.out_data, exp_ct); else n_pass++;
            for (int i = 0; i < hold; i++) tick;
            bus.out_ready = 1'b1;
            tick;
            n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rand%0d_drop: out_valid got %b want 0", n, bus.out_valid); else n_pass++;
        end
    endtask

`ifdef AES_KEY_LATCH_EN
    task automatic test_key_latch;
        int cnt;
        bus.out_ready = 1'b1;
        start_block(C1_PT, C1_KEY);
        tick;
        tick;
        words = expand(128'h0);
        wait_out(cnt);
        n_total++; if (bus.out_data !== C1_CT) $display("FAIL key_latch: got %h want %h", bus.out_data, C1_CT); else n_pass++;
        tick;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        test_reset();
        test_fips_c1_trace();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef AES_KEY_LATCH_EN
        test_key_latch();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
